// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants and request types for the register-file
//                write path.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 64;
    localparam int ZERO_REG = 31;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t addr;
        reg_data_t data;
    } wr_req_t;

endpackage
`default_nettype wire

// File: rtl/decoder_5to32.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_5to32
//  Description : Gated binary-to-one-hot decoder producing per-register
//                write enables.
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_5to32
    import regfile_pkg::*;
#(
    parameter int IN_W  = ADDR_W,
    parameter int OUT_W = NUM_REGS
) (
    input  logic             enable,
    input  logic [IN_W-1:0]  addr,
    output logic [OUT_W-1:0] onehot
);

    for (genvar i = 0; i < OUT_W; i++) begin : g_bit
        assign onehot[i] = enable && (addr == IN_W'(i));
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Round-robin arbiter sharing the register-file write port
//                between two writeback requesters, with a registered
//                one-hot write stage and zero-register suppression.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic [DATA_W-1:0]   req0_data,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic [DATA_W-1:0]   req1_data,
    output logic                req1_ready,
    output logic [NUM_REGS-1:0] wr_enable,
    output logic [DATA_W-1:0]   wr_data,
    output logic                pend_valid,
    output logic [ADDR_W-1:0]   pend_addr
);

    wr_req_t             w_req0;
    wr_req_t             w_req1;
    logic                w_grant0;
    logic                w_grant1;
    logic                w_accept;
    reg_addr_t           w_selAddr;
    reg_data_t           w_selData;
    logic                w_writeEn;
    logic [NUM_REGS-1:0] w_decOut;

    logic                r_prio;
    logic [NUM_REGS-1:0] r_wrEnable;
    reg_data_t           r_wrData;
    logic                r_pendValid;
    reg_addr_t           r_pendAddr;

    always_comb begin
        w_req0 = '{valid: req0_valid, addr: req0_addr, data: req0_data};
        w_req1 = '{valid: req1_valid, addr: req1_addr, data: req1_data};
    end

    // r_prio names the requester favoured when both are valid
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!reset) begin
            if (w_req0.valid && w_req1.valid) begin
                w_grant0 = ~r_prio;
                w_grant1 = r_prio;
            end else begin
                w_grant0 = w_req0.valid;
                w_grant1 = w_req1.valid;
            end
        end
    end

    always_comb begin
        w_accept  = w_grant0 | w_grant1;
        w_selAddr = w_grant1 ? w_req1.addr : w_req0.addr;
        w_selData = w_grant1 ? w_req1.data : w_req0.data;
        // Zero-register writes complete the handshake but never enable a register
        w_writeEn = w_accept && (w_selAddr != reg_addr_t'(ZERO_REG));
    end

    decoder_5to32 #(
        .IN_W  (ADDR_W),
        .OUT_W (NUM_REGS)
    ) u_decoder (
        .enable (w_writeEn),
        .addr   (w_selAddr),
        .onehot (w_decOut)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio      <= 1'b0;
            r_wrEnable  <= '0;
            r_wrData    <= '0;
            r_pendValid <= 1'b0;
            r_pendAddr  <= '0;
        end else begin
            r_wrEnable  <= w_decOut;
            r_pendValid <= w_writeEn;
            if (w_accept) begin
                r_prio     <= w_grant0;
                r_wrData   <= w_selData;
                r_pendAddr <= w_selAddr;
            end
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign wr_enable  = r_wrEnable;
    assign wr_data    = r_wrData;
    assign pend_valid = r_pendValid;
    assign pend_addr  = r_pendAddr;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_arbiter
//  Description : Self-checking bench for regfile_write_arbiter against a
//                behavioural arbitration and register-file model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0;
    logic [4:0]  req0_addr = '0;
    logic [63:0] req0_data = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [4:0]  req1_addr = '0;
    logic [63:0] req1_data = '0;
    logic        req1_ready;
    logic [31:0] wr_enable;
    logic [63:0] wr_data;
    logic        pend_valid;
    logic [4:0]  pend_addr;

    int nTests = 0;
    int nFail  = 0;

    int          mPrio;
    logic [31:0] mWrEn;
    logic [63:0] mWrData;
    logic        mPendV;
    logic [4:0]  mPendA;
    logic [63:0] mRegs   [32];
    logic [63:0] dutRegs [32];
    logic        expG0, expG1, obsR0, obsR1;

    regfile_write_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .wr_enable  (wr_enable),
        .wr_data    (wr_data),
        .pend_valid (pend_valid),
        .pend_addr  (pend_addr)
    );

    always #5 clk = ~clk;

    property pHold0;
        @(posedge clk) disable iff (reset)
        (req0_valid && !req0_ready) |=> (req0_valid && $stable(req0_addr) && $stable(req0_data));
    endproperty
    property pHold1;
        @(posedge clk) disable iff (reset)
        (req1_valid && !req1_ready) |=> (req1_valid && $stable(req1_addr) && $stable(req1_data));
    endproperty
    aHold0: assert property (pHold0) else $error("requester 0 dropped or changed a waiting request");
    aHold1: assert property (pHold1) else $error("requester 1 dropped or changed a waiting request");

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [63:0] d1);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
    endtask

    // One clock: model grant and register capture at negedge, model state update at posedge.
    task automatic step();
        logic [4:0]  a;
        logic [63:0] d;
        @(negedge clk);
        if (reset) begin
            expG0 = 1'b0; expG1 = 1'b0;
        end else if (req0_valid && req1_valid) begin
            expG0 = (mPrio == 0); expG1 = (mPrio == 1);
        end else begin
            expG0 = req0_valid; expG1 = req1_valid;
        end
        obsR0 = req0_ready;
        obsR1 = req1_ready;
        for (int i = 0; i < 32; i++) if (wr_enable[i] === 1'b1) dutRegs[i] = wr_data;
        if (mPendV) mRegs[mPendA] = mWrData;
        @(posedge clk);
        if (reset) begin
            mPrio = 0; mWrEn = '0; mWrData = '0; mPendV = 1'b0; mPendA = '0;
        end else if (expG0 || expG1) begin
            a = expG1 ? req1_addr : req0_addr;
            d = expG1 ? req1_data : req0_data;
            mPrio   = expG1 ? 0 : 1;
            mWrData = d;
            mPendA  = a;
            mPendV  = (a != 5'd31);
            mWrEn   = mPendV ? (32'd1 << a) : 32'd0;
        end else begin
            mPendV = 1'b0;
            mWrEn  = '0;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 5'd1, 64'd11, 1'b1, 5'd2, 64'd22);
        for (int c = 0; c < 2; c++) begin
            step();
            nTests++; if (obsR0 !== 1'b0) begin nFail++; $display("FAIL reset_ready0: got %b expected 0", obsR0); end
            nTests++; if (obsR1 !== 1'b0) begin nFail++; $display("FAIL reset_ready1: got %b expected 0", obsR1); end
            nTests++; if (wr_enable !== 32'h0) begin nFail++; $display("FAIL reset_wr_enable: got %h expected 0", wr_enable); end
            nTests++; if (pend_valid !== 1'b0) begin nFail++; $display("FAIL reset_pend_valid: got %b expected 0", pend_valid); end
        end
        nTests++; if (wr_data !== 64'h0) begin nFail++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
        reset = 1'b0;
        step();
        nTests++; if (obsR0 !== 1'b1 || obsR1 !== 1'b0) begin nFail++; $display("FAIL release_grant: got r0=%b r1=%b expected r0=1 r1=0", obsR0, obsR1); end
        nTests++; if (wr_enable !== 32'h4 >> 1 || wr_data !== 64'd11) begin nFail++; $display("FAIL release_write: got en=%h data=%h expected en=2 data=b", wr_enable, wr_data); end
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd2, 64'd22);
        step();
        nTests++; if (obsR1 !== 1'b1) begin nFail++; $display("FAIL release_second_grant: got %b expected 1", obsR1); end
        nTests++; if (wr_enable !== 32'h4 || pend_addr !== 5'd2) begin nFail++; $display("FAIL release_second_write: got en=%h addr=%0d expected en=4 addr=2", wr_enable, pend_addr); end
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    task automatic test_single();
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'h0000010204080001);
        step();
        nTests++; if (obsR1 !== 1'b1 || obsR0 !== 1'b0) begin nFail++; $display("FAIL single_ready: got r0=%b r1=%b expected r0=0 r1=1", obsR0, obsR1); end
        nTests++; if (wr_enable !== 32'h00000020) begin nFail++; $display("FAIL single_wr_enable: got %h expected 00000020", wr_enable); end
        nTests++; if (wr_data !== 64'h0000010204080001) begin nFail++; $display("FAIL single_wr_data: got %h expected 0000010204080001", wr_data); end
        nTests++; if (pend_valid !== 1'b1 || pend_addr !== 5'd5) begin nFail++; $display("FAIL single_pend: got v=%b a=%0d expected v=1 a=5", pend_valid, pend_addr); end
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        step();
        nTests++; if (wr_enable !== 32'h0 || pend_valid !== 1'b0) begin nFail++; $display("FAIL single_idle: got en=%h v=%b expected en=0 v=0", wr_enable, pend_valid); end
        nTests++; if (wr_data !== 64'h0000010204080001) begin nFail++; $display("FAIL single_hold_data: got %h expected 0000010204080001", wr_data); end
    endtask

    task automatic test_alternate();
        drive(1'b1, 5'd3, 64'hA0, 1'b1, 5'd7, 64'hB0);
        for (int i = 0; i < 6; i++) begin
            step();
            nTests++; if (obsR0 !== (i % 2 == 0) || obsR1 !== (i % 2 == 1)) begin nFail++; $display("FAIL alt_grant[%0d]: got r0=%b r1=%b expected r0=%b r1=%b", i, obsR0, obsR1, (i % 2 == 0), (i % 2 == 1)); end
            nTests++; if (wr_enable !== ((i % 2 == 0) ? 32'h8 : 32'h80) || wr_data !== ((i % 2 == 0) ? 64'hA0 : 64'hB0)) begin nFail++; $display("FAIL alt_write[%0d]: got en=%h data=%h", i, wr_enable, wr_data); end
        end
        drive(1'b1, 5'd3, 64'hA0, 1'b0, 5'd0, 64'd0);
        step();
        nTests++; if (obsR0 !== 1'b1) begin nFail++; $display("FAIL alt_tail: got %b expected 1", obsR0); end
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 5'd31, 64'hFFFF, 1'b0, 5'd0, 64'd0);
        step();
        nTests++; if (obsR0 !== 1'b1) begin nFail++; $display("FAIL zero_ready: got %b expected 1", obsR0); end
        nTests++; if (wr_enable !== 32'h0 || pend_valid !== 1'b0) begin nFail++; $display("FAIL zero_suppress: got en=%h v=%b expected en=0 v=0", wr_enable, pend_valid); end
        nTests++; if (wr_data !== 64'hFFFF || pend_addr !== 5'd31) begin nFail++; $display("FAIL zero_load: got data=%h addr=%0d expected data=ffff addr=31", wr_data, pend_addr); end
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        step();
    endtask

    task automatic test_same_addr();
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'h77);
        step();
        nTests++; if (obsR1 !== 1'b1) begin nFail++; $display("FAIL same_prime: got %b expected 1", obsR1); end
        drive(1'b1, 5'd9, 64'd1, 1'b1, 5'd9, 64'd2);
        step();
        nTests++; if (obsR0 !== 1'b1 || obsR1 !== 1'b0) begin nFail++; $display("FAIL same_first_grant: got r0=%b r1=%b expected r0=1 r1=0", obsR0, obsR1); end
        nTests++; if (wr_enable !== 32'h200 || wr_data !== 64'd1) begin nFail++; $display("FAIL same_first_write: got en=%h data=%h expected en=200 data=1", wr_enable, wr_data); end
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'd2);
        step();
        nTests++; if (obsR1 !== 1'b1) begin nFail++; $display("FAIL same_second_grant: got %b expected 1", obsR1); end
        nTests++; if (wr_enable !== 32'h200 || wr_data !== 64'd2) begin nFail++; $display("FAIL same_second_write: got en=%h data=%h expected en=200 data=2", wr_enable, wr_data); end
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        step();
        nTests++; if (dutRegs[9] !== 64'd2) begin nFail++; $display("FAIL same_final_value: got %h expected 2", dutRegs[9]); end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 5'd4, 64'h44, 1'b1, 5'd6, 64'h66);
        step();
        nTests++; if (obsR0 !== 1'b1 || wr_enable !== 32'h10) begin nFail++; $display("FAIL mid_accept: got r0=%b en=%h expected r0=1 en=10", obsR0, wr_enable); end
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd6, 64'h66);
        reset = 1'b1;
        step();
        nTests++; if (obsR0 !== 1'b0 || obsR1 !== 1'b0) begin nFail++; $display("FAIL mid_reset_ready: got r0=%b r1=%b expected both 0", obsR0, obsR1); end
        nTests++; if (wr_enable !== 32'h0 || pend_valid !== 1'b0) begin nFail++; $display("FAIL mid_reset_clear: got en=%h v=%b expected en=0 v=0", wr_enable, pend_valid); end
        reset = 1'b0;
        drive(1'b1, 5'd10, 64'h100, 1'b1, 5'd6, 64'h66);
        step();
        nTests++; if (obsR0 !== 1'b1 || obsR1 !== 1'b0) begin nFail++; $display("FAIL mid_prio_restart: got r0=%b r1=%b expected r0=1 r1=0", obsR0, obsR1); end
        nTests++; if (wr_enable !== 32'h400) begin nFail++; $display("FAIL mid_after_write: got %h expected 400", wr_enable); end
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd6, 64'h66);
        step();
        nTests++; if (obsR1 !== 1'b1 || wr_enable !== 32'h40) begin nFail++; $display("FAIL mid_waiter_served: got r1=%b en=%h expected r1=1 en=40", obsR1, wr_enable); end
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        step();
    endtask

    task automatic test_random();
        logic        p0v = 1'b0, p1v = 1'b0;
        logic [4:0]  p0a = '0, p1a = '0;
        logic [63:0] p0d = '0, p1d = '0;
        for (int c = 0; c < 400 || ((p0v || p1v) && c < 410); c++) begin
            if (c < 400) begin
                if (!p0v && $urandom_range(0, 2) != 0) begin p0v = 1'b1; p0a = 5'($urandom_range(0, 31)); p0d = {$urandom, $urandom}; end
                if (!p1v && $urandom_range(0, 2) != 0) begin p1v = 1'b1; p1a = 5'($urandom_range(0, 31)); p1d = {$urandom, $urandom}; end
            end
            drive(p0v, p0a, p0d, p1v, p1a, p1d);
            step();
            nTests++; if (obsR0 !== expG0 || obsR1 !== expG1) begin nFail++; $display("FAIL rand_grant[%0d]: got r0=%b r1=%b expected r0=%b r1=%b", c, obsR0, obsR1, expG0, expG1); end
            nTests++; if (wr_enable !== mWrEn) begin nFail++; $display("FAIL rand_wr_enable[%0d]: got %h expected %h", c, wr_enable, mWrEn); end
            nTests++; if (wr_data !== mWrData) begin nFail++; $display("FAIL rand_wr_data[%0d]: got %h expected %h", c, wr_data, mWrData); end
            nTests++; if (pend_valid !== mPendV || pend_addr !== mPendA) begin nFail++; $display("FAIL rand_pend[%0d]: got v=%b a=%0d expected v=%b a=%0d", c, pend_valid, pend_addr, mPendV, mPendA); end
            nTests++; if ($countones(wr_enable) > 1) begin nFail++; $display("FAIL rand_onehot[%0d]: got %h expected at most one bit", c, wr_enable); end
            if (expG0) p0v = 1'b0;
            if (expG1) p1v = 1'b0;
        end
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        step();
        step();
        nTests++; if (p0v || p1v) begin nFail++; $display("FAIL rand_drain: got pending r0=%b r1=%b expected none", p0v, p1v); end
        for (int i = 0; i < 32; i++) begin
            nTests++; if (dutRegs[i] !== mRegs[i]) begin nFail++; $display("FAIL rand_regfile[%0d]: got %h expected %h", i, dutRegs[i], mRegs[i]); end
        end
    endtask

    initial begin
        mPrio = 0; mWrEn = '0; mWrData = '0; mPendV = 1'b0; mPendA = '0;
        for (int i = 0; i < 32; i++) begin mRegs[i] = '0; dutRegs[i] = '0; end
        test_reset();
        test_single();
        test_alternate();
        test_zero_reg();
        test_same_addr();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
